// File: rtl/tlp_xcvr_pkg.sv
// Shared types and sizing for the PCIe TLP transmit path.
package tlp_xcvr_pkg;
    localparam int F2C_TLPSIZE  = 128;
    // Two header QWs, the F2C payload in QWs, and two beats of margin.
    localparam int TX_MAX_BEATS = 2 + F2C_TLPSIZE / 8 + 2;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } TxBeat;

    typedef enum logic {
        S_OFFER = 1'b0,
        S_PKT   = 1'b1
    } ArbState;
endpackage

// File: rtl/tlp_tx_arbiter_rr_next_idx.sv
// Round-robin successor of an index in 0..NUM-1, with explicit wrap for non-power-of-two NUM.
module rr_next_idx #(
    parameter int NUM = 2,
    parameter int W   = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [W-1:0] curIdx,
    output logic [W-1:0] nextIdx
);
    always_comb begin
        if (curIdx == W'(NUM - 1)) nextIdx = '0;
        else                       nextIdx = curIdx + 1'b1;
    end
endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the 64-bit PCIe TX channel between NUM_SRC TLP generators.
module tlp_tx_arbiter
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BEATS = TX_MAX_BEATS
) (
    input  logic                         pcieClk_in,
    input  logic                         pcieRstN_in,
    input  logic [NUM_SRC*64-1:0]        srcData_in,
    input  logic [NUM_SRC-1:0]           srcValid_in,
    input  logic [NUM_SRC-1:0]           srcSOP_in,
    input  logic [NUM_SRC-1:0]           srcEOP_in,
    output logic [NUM_SRC-1:0]           srcReady_out,
    output logic [63:0]                  txData_out,
    output logic                         txValid_out,
    output logic                         txSOP_out,
    output logic                         txEOP_out,
    input  logic                         txReady_in,
    output logic                         errSticky_out,
    output logic [$clog2(NUM_SRC)-1:0]   errSrc_out,
    output logic                         dbgState_out,
    output logic [$clog2(NUM_SRC)-1:0]   dbgCand_out
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    ArbState          state;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] candNext;
    logic [CNT_W-1:0] beatCount;
    logic [CNT_W-1:0] beatsNow;
    logic             errSticky;
    logic [IDX_W-1:0] errSrc;
    TxBeat            candBeat;
    logic             xfer;
    logic             errEvent;

    rr_next_idx #(.NUM(NUM_SRC), .W(IDX_W)) uNextIdx (
        .curIdx (cand),
        .nextIdx(candNext)
    );

    // Handshake: a beat moves in any cycle where the candidate's valid and txReady_in are both high;
    // ready is shown to the candidate only, and sources raise valid only while their ready is high.
    always_comb begin
        candBeat.data = srcData_in[64*cand +: 64];
        candBeat.sop  = srcSOP_in[cand];
        candBeat.eop  = srcEOP_in[cand];
        xfer          = txReady_in & srcValid_in[cand];

        srcReady_out       = '0;
        srcReady_out[cand] = txReady_in & pcieRstN_in;
        txData_out         = candBeat.data;
        txSOP_out          = candBeat.sop;
        txEOP_out          = candBeat.eop;
        txValid_out        = xfer & pcieRstN_in;

        // Beat count including the beat currently on the bus; saturates at the limit.
        beatsNow = (beatCount == CNT_W'(MAX_BEATS)) ? beatCount : beatCount + 1'b1;

        errEvent = 1'b0;
        if (xfer) begin
            if (state == S_OFFER) errEvent = !candBeat.sop;
            else                  errEvent = candBeat.sop ||
                                             (!candBeat.eop && beatsNow == CNT_W'(MAX_BEATS));
        end
    end

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state     <= S_OFFER;
            cand      <= '0;
            beatCount <= '0;
            errSticky <= 1'b0;
            errSrc    <= '0;
        end else begin
            if (errEvent && !errSticky) begin
                errSticky <= 1'b1;
                errSrc    <= cand;
            end
            case (state)
                S_OFFER: begin
                    // Offer only rotates when the core could have taken a beat.
                    if (txReady_in) begin
                        if (xfer && candBeat.sop && !candBeat.eop) begin
                            state     <= S_PKT;
                            beatCount <= CNT_W'(1);
                        end else begin
                            cand <= candNext;
                        end
                    end
                end
                S_PKT: begin
                    if (xfer) begin
                        if (candBeat.eop || beatsNow == CNT_W'(MAX_BEATS)) begin
                            state     <= S_OFFER;
                            cand      <= candNext;
                            beatCount <= '0;
                        end else begin
                            beatCount <= beatsNow;
                        end
                    end
                end
                default: state <= S_OFFER;
            endcase
        end
    end

    assign errSticky_out = errSticky;
    assign errSrc_out    = errSrc;
    assign dbgState_out  = state;
    assign dbgCand_out   = cand;
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Randomized bench for tlp_tx_arbiter with a packet-level reference model and literal scenario checks.
module tb_tlp_tx_arbiter;
  import tlp_xcvr_pkg::*;

  localparam int NUM_SRC   = 2;
  localparam int MAX_BEATS = TX_MAX_BEATS;

  logic                  pcieClk_in = 1'b0;
  logic                  pcieRstN_in;
  logic [NUM_SRC*64-1:0] srcData_in;
  logic [NUM_SRC-1:0]    srcValid_in, srcSOP_in, srcEOP_in, srcReady_out;
  logic [63:0]           txData_out;
  logic                  txValid_out, txSOP_out, txEOP_out, txReady_in, errSticky_out;
  logic [0:0]            errSrc_out;
  logic                  dbgState_out;
  logic [0:0]            dbgCand_out;

  tlp_tx_arbiter #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS)) dut (
    .pcieClk_in(pcieClk_in), .pcieRstN_in(pcieRstN_in),
    .srcData_in(srcData_in), .srcValid_in(srcValid_in), .srcSOP_in(srcSOP_in), .srcEOP_in(srcEOP_in),
    .srcReady_out(srcReady_out),
    .txData_out(txData_out), .txValid_out(txValid_out), .txSOP_out(txSOP_out), .txEOP_out(txEOP_out),
    .txReady_in(txReady_in),
    .errSticky_out(errSticky_out), .errSrc_out(errSrc_out),
    .dbgState_out(dbgState_out), .dbgCand_out(dbgCand_out)
  );

  // ---------------- clock ----------------
  always #10 pcieClk_in = ~pcieClk_in;

  int total = 0;
  int bad   = 0;

  TxBeat       q0[$];
  TxBeat       q1[$];
  logic [63:0] exp_q[$];
  int          scbSrc   = -1;
  int          validPct = 100;

  // reference model: who holds the offer, whether a packet is open, and its length so far
  int  mCand, mBeats, mErrSrc;
  bit  mInPkt, mErr, mWdog;
  int  pktLog[$];
  int  cycles  = 0;
  int  txBeats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic TxBeat q_head(int s);
    return (s == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(int s);
    if (s == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic TxBeat mk(logic [63:0] d, logic sop, logic eop);
    TxBeat b;
    b.data = d; b.sop = sop; b.eop = eop;
    return b;
  endfunction

  function automatic void q_push(int s, TxBeat b);
    if (s == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  task automatic load_pkt(input int s, input int len, input int tag);
    for (int i = 0; i < len; i++)
      q_push(s, mk({16'hA000 | 16'(tag), 16'(s), 32'(i)}, 1'(i == 0), 1'(i == len - 1)));
  endtask

  function automatic void model_reset();
    mCand = 0; mBeats = 0; mErrSrc = 0; mInPkt = 0; mErr = 0; mWdog = 0;
  endfunction

  function automatic void rec_err();
    if (!mErr) begin mErr = 1; mErrSrc = mCand; end
  endfunction

  function automatic void advance();
    mCand = (mCand + 1) % NUM_SRC;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_src();
    for (int s = 0; s < NUM_SRC; s++) begin
      if (srcReady_out[s] && q_size(s) > 0 && $urandom_range(99) < validPct) begin
        TxBeat b;
        b = q_head(s);
        srcData_in[64*s +: 64] = b.data;
        srcSOP_in[s]   = b.sop;
        srcEOP_in[s]   = b.eop;
        srcValid_in[s] = 1'b1;
      end else begin
        srcData_in[64*s +: 64] = {$urandom, $urandom};
        srcSOP_in[s]   = 1'($urandom_range(1));
        srcEOP_in[s]   = 1'($urandom_range(1));
        srcValid_in[s] = 1'b0;
      end
    end
  endtask

  // ---------------- compare + model step ----------------
  task automatic check_update();
    logic [1:0] expReady;
    bit         expValid;
    TxBeat      b;
    expReady = txReady_in ? 2'(1 << mCand) : 2'b00;
    expValid = txReady_in && srcValid_in[mCand];
    check("srcReady",  64'(srcReady_out),  64'(expReady));
    check("txValid",   64'(txValid_out),   64'(expValid));
    check("errSticky", 64'(errSticky_out), 64'(mErr));
    check("errSrc",    64'(errSrc_out),    64'(mErrSrc));
    check("dbgState",  64'(dbgState_out),  64'(mInPkt ? S_PKT : S_OFFER));
    check("dbgCand",   64'(dbgCand_out),   64'(mCand));
    mWdog = 0;
    if (expValid) begin
      b = q_head(mCand);
      check("txData", txData_out,      b.data);
      check("txSOP",  64'(txSOP_out),  64'(b.sop));
      check("txEOP",  64'(txEOP_out),  64'(b.eop));
      if (scbSrc == mCand && exp_q.size() > 0) check("scoreboard", txData_out, exp_q.pop_front());
      q_pop(mCand);
      txBeats++;
      if (!mInPkt) begin
        if (!b.sop) begin
          rec_err(); advance();
        end else begin
          pktLog.push_back(mCand);
          if (b.eop) advance();
          else begin mInPkt = 1; mBeats = 1; end
        end
      end else begin
        mBeats++;
        if (b.sop) rec_err();
        if (b.eop) begin
          mInPkt = 0; advance();
        end else if (mBeats == MAX_BEATS) begin
          rec_err(); mWdog = 1; mInPkt = 0; advance();
        end
      end
    end else if (!mInPkt && txReady_in) begin
      advance();
    end
    cycles++;
  endtask

  task automatic step(input int readyPct);
    @(negedge pcieClk_in);
    txReady_in = ($urandom_range(99) < readyPct);
    #1 drive_src();
    #1 check_update();
  endtask

  task automatic run_until_empty(input string name, input int readyPct, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      step(readyPct);
      n++;
    end
    total++;
    if (q0.size() > 0 || q1.size() > 0) begin
      bad++;
      $display("FAIL %s_timeout: left %0d/%0d beats within %0d cycles", name, q0.size(), q1.size(), budget);
    end
  endtask

  task automatic hard_reset();
    @(negedge pcieClk_in);
    pcieRstN_in = 1'b0;
    txReady_in  = 1'b0;
    srcValid_in = '0;
    q0.delete(); q1.delete(); exp_q.delete();
    model_reset();
    @(negedge pcieClk_in);
    pcieRstN_in = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, b0, wdSeen;
    int expLog[6];
    expLog = '{1, 0, 1, 0, 1, 0};

    pcieRstN_in = 1'b0;
    txReady_in  = 1'b1;
    srcValid_in = '1;
    srcSOP_in   = '1;
    srcEOP_in   = '0;
    srcData_in  = '0;
    model_reset();
    repeat (3) @(negedge pcieClk_in);
    #1;
    check("rst_srcReady",  64'(srcReady_out),  64'(0));
    check("rst_txValid",   64'(txValid_out),   64'(0));
    check("rst_errSticky", 64'(errSticky_out), 64'(0));
    check("rst_state",     64'(dbgState_out),  64'(S_OFFER));
    check("rst_cand",      64'(dbgCand_out),   64'(0));
    @(negedge pcieClk_in);
    pcieRstN_in = 1'b1;
    txReady_in  = 1'b0;
    srcValid_in = '0;

    // single source, back-to-back 18-beat packets
    for (int p = 0; p < 3; p++) load_pkt(0, 18, p);
    c0 = cycles; b0 = txBeats;
    run_until_empty("t1", 100, 200);
    check("t1_cycles", 64'(cycles - c0), 64'(56));
    check("t1_beats",  64'(txBeats - b0), 64'(54));
    @(posedge pcieClk_in); #1;
    check("t1_noerr", 64'(errSticky_out), 64'(0));

    // both sources continuously valid: long DMA packets vs short completions
    pktLog.delete();
    for (int p = 0; p < 3; p++) begin
      load_pkt(0, 18, 16 + p);
      load_pkt(1, 2, 32 + p);
    end
    run_until_empty("t2", 100, 300);
    check("t2_pkts", 64'(pktLog.size()), 64'(6));
    for (int i = 0; i < 6 && i < pktLog.size(); i++) check("t2_order", 64'(pktLog[i]), 64'(expLog[i]));

    // 50% core backpressure during one src1 packet
    load_pkt(1, 18, 48);
    foreach (q1[i]) exp_q.push_back(q1[i].data);
    scbSrc = 1;
    begin
      int n;
      bit wasInPkt;
      n = 0;
      while (q1.size() > 0 && n < 400) begin
        wasInPkt = mInPkt;
        step(50);
        if (wasInPkt) check("t3_ready0", 64'(srcReady_out[0]), 64'(0));
        n++;
      end
      total++;
      if (q1.size() > 0) begin bad++; $display("FAIL t3_timeout: %0d beats left", q1.size()); end
    end
    check("t3_scb_drained", 64'(exp_q.size()), 64'(0));

    // protocol error: src0 valid without SOP while being offered
    q_push(0, mk(64'hDEAD_0000_0000_0001, 1'b0, 1'b0));
    load_pkt(1, 2, 64);
    foreach (q1[i]) exp_q.push_back(q1[i].data);
    run_until_empty("t4", 100, 40);
    check("t4_scb_drained", 64'(exp_q.size()), 64'(0));
    scbSrc = -1;
    @(posedge pcieClk_in); #1;
    check("t4_errSticky", 64'(errSticky_out), 64'(1));
    check("t4_errSrc",    64'(errSrc_out),    64'(0));

    // asynchronous reset pulse in the middle of a src1 packet
    load_pkt(1, 18, 80);
    begin
      int n;
      n = 0;
      while (!(mInPkt && mBeats >= 5) && n < 60) begin step(100); n++; end
      check("t6_reached_mid", 64'(mInPkt && mBeats >= 5), 64'(1));
    end
    @(negedge pcieClk_in);
    txReady_in = 1'b1;
    #1 drive_src();
    #1 pcieRstN_in = 1'b0;
    #1;
    check("t6_ready_low", 64'(srcReady_out), 64'(0));
    check("t6_valid_low", 64'(txValid_out),  64'(0));
    #1 pcieRstN_in = 1'b1;
    #1;
    check("t6_state", 64'(dbgState_out),  64'(S_OFFER));
    check("t6_cand",  64'(dbgCand_out),   64'(0));
    check("t6_err",   64'(errSticky_out), 64'(0));
    q0.delete(); q1.delete();
    model_reset();
    drive_src();
    #1 check_update();

    // watchdog: src1 streams 25 beats with no EOP
    q_push(1, mk(64'h5A5A_0000_0000_0000, 1'b1, 1'b0));
    for (int i = 1; i < 25; i++) q_push(1, mk(64'h5A5A_0000_0000_0000 | 64'(i), 1'b0, 1'b0));
    wdSeen = 0;
    begin
      int n;
      n = 0;
      while (q1.size() > 0 && n < 100) begin
        step(100);
        n++;
        if (mWdog) begin
          wdSeen++;
          check("t5_beats_at_wdog", 64'(25 - q1.size()), 64'(20));
          @(posedge pcieClk_in); #1;
          check("t5_errSticky", 64'(errSticky_out), 64'(1));
          check("t5_errSrc",    64'(errSrc_out),    64'(1));
          check("t5_state",     64'(dbgState_out),  64'(S_OFFER));
          check("t5_cand",      64'(dbgCand_out),   64'(0));
          check("t5_ready",     64'(srcReady_out),  64'(2'b01));
        end
      end
    end
    check("t5_wdog_hit", 64'(wdSeen), 64'(1));

    // randomized traffic with legal packets of 1..MAX_BEATS beats
    hard_reset();
    validPct = 70;
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < NUM_SRC; s++)
        if (q_size(s) == 0 && $urandom_range(3) == 0) load_pkt(s, $urandom_range(1, MAX_BEATS), 100 + c);
      step(70);
    end
    validPct = 100;
    run_until_empty("rand_drain", 100, 200);
    @(posedge pcieClk_in); #1;
    check("rand_noerr", 64'(errSticky_out), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
- Shares the single 64-bit PCIe TX channel between NUM_SRC independent TLP generators, e.g. the register/F2C-DMA sender and a C2F DMA read-request generator.
- Grants are packet-atomic and round-robin. Once a source starts a packet with SOP, it keeps the channel until EOP.
- Sits between the TLP generators and the PCIe hard-IP TX interface.
- Sources use ready-before-valid: a source asserts valid only in a cycle where its ready is high.

Parameters:
- NUM_SRC, 2, number of TLP sources (2..8).
- MAX_BEATS, 20, watchdog limit on beats per packet, counting SOP and EOP beats.

Ports:
- pcieClk_in  in  1  125MHz PCIe core clock; sole clock.
- pcieRstN_in  in  1  reset; asynchronous assert, active-low.
- srcData_in  in  NUM_SRC x 64  per-source TLP beat data.
- srcValid_in  in  NUM_SRC  per-source beat valid.
- srcSOP_in  in  NUM_SRC  per-source start of packet.
- srcEOP_in  in  NUM_SRC  per-source end of packet.
- srcReady_out  out  NUM_SRC  per-source ready; at most one bit high.
- txData_out  out  64  to PCIe core.
- txValid_out  out  1  to PCIe core.
- txSOP_out  out  1  to PCIe core.
- txEOP_out  out  1  to PCIe core.
- txReady_in  in  1  from PCIe core.
- errSticky_out  out  1  protocol-error flag; cleared only by reset.
- errSrc_out  out  $clog2(NUM_SRC)  source that caused the first error.

Behaviour:
- Registers:
  - state: S_OFFER or S_PKT.
  - cand: candidate or owner index.
  - beatCount.
  - errSticky, errSrc.
- Reset, asynchronous while pcieRstN_in=0:
  - state=S_OFFER, cand=0, beatCount=0, errSticky=0, errSrc=0.
  - All srcReady_out=0 and txValid_out=0 while reset is held.
- Datapath is a combinational mux with zero latency:
  - srcReady_out[cand] = txReady_in; all other bits are 0.
  - tx{Data,SOP,EOP}_out = src*_in[cand].
  - txValid_out = srcValid_in[cand] & txReady_in.
  - No beat is ever presented to the core while txReady_in=0.
- A beat transfers in a cycle where txReady_in & srcValid_in[cand] are both high.
- S_OFFER, one source is offered per cycle:
  - Beat with SOP=1 and EOP=0: state->S_PKT, beatCount=1, cand unchanged.
  - Beat with SOP=1 and EOP=1 (single-beat packet): stay in S_OFFER; cand = cand+1 mod NUM_SRC.
  - Beat with SOP=0 (protocol error): the beat is still forwarded. If errSticky=0, set errSticky and errSrc=cand. cand advances.
  - No beat: cand = cand+1 mod NUM_SRC. This gives an idle source a worst-case wait of NUM_SRC-1 cycles.
  - txReady_in=0: cand holds, so the offer is not wasted.
- S_PKT, owner is cand; other sources see ready=0:
  - Each transferred beat increments beatCount.
  - Beat with EOP=1: state->S_OFFER, cand = cand+1 mod NUM_SRC, beatCount=0.
  - Beat with SOP=1 mid-packet: record error as above; the beat is forwarded and the packet continues.
  - Watchdog: when beatCount==MAX_BEATS and the transferring beat is not EOP, record error, force state->S_OFFER, and advance cand. Downstream is left unterminated; this case is logged as fatal.
  - txReady_in deasserting mid-packet: stall, all state holds, no timeout on stalls.
- Widths:
  - beatCount is $clog2(MAX_BEATS+1) bits and saturates.
  - cand wrap is explicit modulo for NUM_SRC values that are not a power of two.
- Fairness: after every completed packet, priority moves to the next index, so no source can send two consecutive packets while another is valid.
- Reset mid-packet: immediately returns to S_OFFER with cand=0. A truncated TLP at the core is the system reset's responsibility.

Decomposition:
- tlp_xcvr_pkg gains the following:
  - TxBeat typedef (data, sop, eop).
  - TX_MAX_BEATS constant (2 header QW + F2C_TLPSIZE/8 payload + 2 margin).
  - Arbiter state enum.
- Sub-module rr_next_idx: combinational modulo-increment of cand. It is kept separate for reuse by the planned C2F tag allocator.

Test Plan:
- Single source, back-to-back 18-beat DMA packets (1 SOP, 16 payload, 1 EOP):
  - Every beat passes with zero latency.
  - Between packets the arbiter rotates through NUM_SRC=2, so at most 1 idle cycle.
  - errSticky stays 0.
- Both sources valid continuously, src0 sends 18-beat packets and src1 sends 2-beat completions:
  - Output packets alternate 0,1,0,1.
  - No interleaving of beats inside any packet.
- txReady_in toggled randomly, 50%, during an 18-beat packet from src1:
  - Packet arrives intact and in order.
  - srcReady_out[0] is 0 throughout.
- src0 asserts valid with SOP=0 in S_OFFER:
  - errSticky=1 and errSrc=0 on the next cycle.
  - The following src1 packet is unaffected.
- src1 sends 25 beats without EOP, MAX_BEATS=20:
  - At beat 20, errSticky=1 and errSrc=1.
  - Arbiter returns to S_OFFER and offers src0 on the next cycle.
- pcieRstN_in pulsed low for 1 ns mid-packet, asynchronous to the clock:
  - srcReady_out and txValid_out go 0 immediately.
  - After release, state=S_OFFER with cand=0.
